i2c_cmd_scheduler: RTL and testbench
====================================

Name: i2c_cmd_scheduler

Overview:
- Shares one i2c_master command path between N_REQ requesters, arbitrating round-robin.
- Writes each winning {addr, data} into the master's command FIFO (fifo_wr_en/data/addr).
- Sequences FIFO pops (fifo_rd_en) against the master's fsm_ready, so one queued command is dispatched per completed I2C transaction.
- Sits directly above i2c_master; sole driver of its data, addr, fifo_wr_en and fifo_rd_en.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_TO, 64, cycles to wait for fsm_ready to fall after a pop before flagging a timeout.
- CNT_W, 16, width of dispatched-transaction counter.

Ports:
- clk  in  1  system clock.
- arst  in  1  reset; asynchronous, active-high.
- req_valid  in  N_REQ  per-requester command valid.
- req_addr  in  7*N_REQ  per-requester 7-bit slave address, requester i at [7i+6:7i].
- req_data  in  8*N_REQ  per-requester data byte, requester i at [8i+7:8i].
- req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- fifo_full  in  1  from i2c_master.
- fifo_empty  in  1  from i2c_master.
- fsm_ready  in  1  from i2c_master; high = master idle.
- data  out  8  command data to i2c_master.
- addr  out  7  command address to i2c_master.
- fifo_wr_en  out  1  one-cycle write strobe.
- fifo_rd_en  out  1  one-cycle pop strobe.
- grant_id  out  $clog2(N_REQ)  index of last accepted requester.
- tx_count  out  CNT_W  completed dispatches, wraps to 0.
- timeout_err  out  1  sticky; set on BUSY_TO expiry.

Behaviour:
- Reset: all outputs 0; RR pointer 0; dispatch state IDLE; counters cleared. arst mid-transfer aborts immediately, with no partial strobe after release.
- Write side:
  - accept_ok = !fifo_full & !fifo_wr_en; fifo_full lags one cycle, so at most one write every 2 cycles.
  - When accept_ok, req_ready is one-hot at the first asserted req_valid searching from the RR pointer upward, modulo N_REQ. req_ready is combinational from req_valid, pointer and accept_ok.
  - On accept of i: next cycle fifo_wr_en=1 for exactly 1 cycle; data/addr are registered copies of req_data[i]/req_addr[i] and hold until the next accept; grant_id=i; pointer=(i+1) mod N_REQ.
  - No valid, or accept_ok=0: req_ready=0 and pointer unchanged.
  - A requester dropping valid without handshake is legal; no state retained.
- Dispatch FSM:
  - IDLE: if fsm_ready & !fifo_empty -> POP.
  - POP: fifo_rd_en=1 for 1 cycle -> WAIT_BUSY; timer cleared.
  - WAIT_BUSY: if !fsm_ready -> WAIT_DONE. Otherwise timer++; at timer==BUSY_TO-1, set timeout_err -> IDLE (command treated as lost).
  - WAIT_DONE: if fsm_ready -> tx_count++ (wrapping) -> IDLE.
- Write side and dispatch FSM run independently; a write and a pop in the same cycle are legal.
- fifo_empty rising while in WAIT_* has no effect until IDLE.
- timeout_err clears only on arst.

Optional Feature:
- I2C_CMD_SCHED_PRIO_EN defined: requester 0 is fixed highest priority and is granted whenever valid; requesters 1..N_REQ-1 are round-robin among themselves, and the pointer never points at 0.
- Undefined: pure round-robin across all N_REQ as above.

Decomposition:
- Package i2c_cmd_pkg: I2C_ADDR_W=7, I2C_DATA_W=8, dispatch state encoding (IDLE, POP, WAIT_BUSY, WAIT_DONE).
- Sub-module rr_arbiter (N parameter; inputs req, ptr; outputs one-hot gnt and encoded index), reused by the priority variant on the 1..N-1 slice.
- FSM and write register stay in the top.

Test Plan:
- Single requester: req 2 valid with addr=0x50, data=0xA5, FIFO empty/not full -> req_ready[2] same cycle; next cycle fifo_wr_en=1, addr=0x50, data=0xA5, grant_id=2.
- All 4 valid continuously, fifo_full=0 -> grant order 0,1,2,3,0 with wr strobes spaced exactly 2 cycles.
- fifo_full=1 while req 1 valid -> req_ready=0 and no fifo_wr_en; deassert full -> accept within 1 cycle.
- fifo_empty=0, fsm_ready=1 -> one fifo_rd_en pulse; model fsm_ready low 20 cycles then high -> no further pop until high, tx_count 0->1.
- After pop, hold fsm_ready=1 for BUSY_TO=64 cycles -> timeout_err=1 at cycle 64 and FSM back in IDLE; arst -> timeout_err=0, all outputs 0.
- With I2C_CMD_SCHED_PRIO_EN: req 0 and req 3 always valid -> req 0 granted every accept slot; drop req 0 -> req 3 granted.

Source files
------------

// File: rtl/i2c_cmd_pkg.sv
// Shared widths, dispatch state encoding and command record for the i2c command scheduler.
package i2c_cmd_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_POP       = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
  } cmd_t;

  // Index width that stays legal for a single-entry arbiter.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr_i, wrapping modulo N.
module rr_arbiter
  import i2c_cmd_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int   pos;
  logic found;

  // Scan from the pointer upward and keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr_i) + k) % N;
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        idx_o      = IW'(pos);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/i2c_cmd_scheduler.sv
// Arbitrates N_REQ requesters into the i2c_master command FIFO and paces FIFO pops against fsm_ready.
// Build option: define I2C_CMD_SCHED_PRIO_EN to give requester 0 fixed top priority.
module i2c_cmd_scheduler
  import i2c_cmd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BUSY_TO = 64,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [I2C_ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [I2C_DATA_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic                          fsm_ready,
  output logic [I2C_DATA_W-1:0]         data,
  output logic [I2C_ADDR_W-1:0]         addr,
  output logic                          fifo_wr_en,
  output logic                          fifo_rd_en,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic [CNT_W-1:0]              tx_count,
  output logic                          timeout_err
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);

  logic [GW-1:0]    ptr_q, ptr_d, ptr_nxt_s;
  logic             wr_en_q;
  cmd_t             cmd_q;
  logic [GW-1:0]    grant_q;
  logic             accept_ok_s, accept_s;
  logic [N_REQ-1:0] win_gnt_s;
  logic [GW-1:0]    win_idx_s;
  logic             win_any_s;

  // fifo_full lags a write by one cycle, so never accept while our own strobe is out.
  assign accept_ok_s = ~arst & ~fifo_full & ~wr_en_q;

`ifdef I2C_CMD_SCHED_PRIO_EN
  localparam int SN = N_REQ - 1;
  localparam int SW = idx_w(SN);
  localparam logic [GW-1:0] PTR_RST = GW'(1);

  logic [SN-1:0] sub_gnt_s;
  logic [SW-1:0] sub_idx_s;
  logic          sub_any_s;
  logic [GW-1:0] sub_ptr_s;

  // The pointer lives in 1..N_REQ-1; the sub-arbiter sees it rebased to 0.
  assign sub_ptr_s = ptr_q - GW'(1);

  rr_arbiter #(.N(SN)) u_arb (
    .req_i (req_valid[N_REQ-1:1]),
    .ptr_i (sub_ptr_s[SW-1:0]),
    .gnt_o (sub_gnt_s),
    .idx_o (sub_idx_s),
    .any_o (sub_any_s)
  );

  // Requester 0 pre-empts the round-robin slice; its grant leaves the pointer alone.
  always_comb begin
    if (req_valid[0]) begin
      win_gnt_s = N_REQ'(1);
      win_idx_s = '0;
      win_any_s = 1'b1;
    end else begin
      win_gnt_s = {sub_gnt_s, 1'b0};
      win_idx_s = GW'(sub_idx_s) + GW'(1);
      win_any_s = sub_any_s;
    end
    if (win_idx_s == '0) begin
      ptr_nxt_s = ptr_q;
    end else if (win_idx_s == LAST_IDX) begin
      ptr_nxt_s = GW'(1);
    end else begin
      ptr_nxt_s = win_idx_s + GW'(1);
    end
  end
`else
  localparam logic [GW-1:0] PTR_RST = '0;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt_s),
    .idx_o (win_idx_s),
    .any_o (win_any_s)
  );

  assign ptr_nxt_s = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + GW'(1);
`endif

  assign accept_s  = accept_ok_s & win_any_s;
  assign req_ready = accept_ok_s ? win_gnt_s : '0;
  assign ptr_d     = accept_s ? ptr_nxt_s : ptr_q;

  // Capture the winning command and raise the one-cycle write strobe.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr_q   <= PTR_RST;
      wr_en_q <= 1'b0;
      cmd_q   <= '0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= accept_s;
      if (accept_s) begin
        cmd_q.addr <= req_addr[win_idx_s*I2C_ADDR_W +: I2C_ADDR_W];
        cmd_q.data <= req_data[win_idx_s*I2C_DATA_W +: I2C_DATA_W];
        grant_q    <= win_idx_s;
      end
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign data       = cmd_q.data;
  assign addr       = cmd_q.addr;
  assign grant_id   = grant_q;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] tx_q, tx_d;
  logic             to_q, to_d;
  logic             rd_en_q;

  // Dispatch sequencing: pop only when the master is idle, then follow its busy/idle handshake.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tx_d    = tx_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (fsm_ready && !fifo_empty) begin
          state_d = ST_POP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POP: begin
        state_d = ST_WAIT_BUSY;
        timer_d = '0;
      end
      ST_WAIT_BUSY: begin
        if (!fsm_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TW'(BUSY_TO - 1)) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (fsm_ready) begin
          tx_d    = tx_q + CNT_W'(1);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dispatch state, counters and the registered pop strobe.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      tx_q    <= '0;
      to_q    <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tx_q    <= tx_d;
      to_q    <= to_d;
      rd_en_q <= (state_d == ST_POP);
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign tx_count    = tx_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// Self-checking bench for i2c_cmd_scheduler: directed scenarios plus a randomized run against a reference model.
module tb_i2c_cmd_scheduler;

  localparam int N       = 4;
  localparam int BUSY_TO = 64;

  logic          clk;
  logic          arst;
  logic [3:0]    req_valid;
  logic [27:0]   req_addr;
  logic [31:0]   req_data;
  logic [3:0]    req_ready;
  logic          fifo_full, fifo_empty, fsm_ready;
  logic [7:0]    data;
  logic [6:0]    addr;
  logic          fifo_wr_en, fifo_rd_en;
  logic [1:0]    grant_id;
  logic [15:0]   tx_count;
  logic          timeout_err;

  int n_pass;
  int n_total;

  i2c_cmd_scheduler #(.N_REQ(N), .BUSY_TO(BUSY_TO), .CNT_W(16)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fsm_ready(fsm_ready),
    .data(data), .addr(addr), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .grant_id(grant_id), .tx_count(tx_count), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    arst       = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    fsm_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req_valid = 4'hF; req_addr = 28'hABCDEF1; req_data = 32'h12345678; fifo_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1 arst = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0) $display("FAIL rst_ready got=%b exp=0", req_ready); else n_pass++;
    n_total++; if (fifo_wr_en !== 1'b0) $display("FAIL rst_wr got=%b exp=0", fifo_wr_en); else n_pass++;
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd got=%b exp=0", fifo_rd_en); else n_pass++;
    n_total++; if (data !== 8'h00) $display("FAIL rst_data got=%h exp=00", data); else n_pass++;
    n_total++; if (addr !== 7'h00) $display("FAIL rst_addr got=%h exp=00", addr); else n_pass++;
    n_total++; if (grant_id !== 2'd0) $display("FAIL rst_gid got=%0d exp=0", grant_id); else n_pass++;
    n_total++; if (tx_count !== 16'd0) $display("FAIL rst_tx got=%0d exp=0", tx_count); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL rst_to got=%b exp=0", timeout_err); else n_pass++;
    req_valid = '0; fifo_empty = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++; if ({fifo_wr_en, fifo_rd_en} !== 2'b00) $display("FAIL rst_no_strobe got=%b exp=00", {fifo_wr_en, fifo_rd_en}); else n_pass++;
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_addr[14 +: 7] = 7'h50; req_data[16 +: 8] = 8'hA5;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0100) $display("FAIL single_ready got=%b exp=0100", req_ready); else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_total++; if (fifo_wr_en !== 1'b1) $display("FAIL single_wr got=%b exp=1", fifo_wr_en); else n_pass++;
    n_total++; if (addr !== 7'h50) $display("FAIL single_addr got=%h exp=50", addr); else n_pass++;
    n_total++; if (data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", data); else n_pass++;
    n_total++; if (grant_id !== 2'd2) $display("FAIL single_gid got=%0d exp=2", grant_id); else n_pass++;
    @(negedge clk);
    n_total++; if (fifo_wr_en !== 1'b0) $display("FAIL single_wr_pulse got=%b exp=0", fifo_wr_en); else n_pass++;
    n_total++; if (addr !== 7'h50) $display("FAIL single_addr_hold got=%h exp=50", addr); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_addr[i*7 +: 7] = 7'(8'h10 + i);
      req_data[i*8 +: 8] = 8'(8'hC0 + i);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_ready = (c % 2 == 0) ? 4'(1 << ((c / 2) % N)) : 4'b0;
      n_total++; if (req_ready !== exp_ready) $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); else n_pass++;
      n_total++; if (fifo_wr_en !== 1'(c % 2)) $display("FAIL rr_wr c=%0d got=%b exp=%0d", c, fifo_wr_en, c % 2); else n_pass++;
      if (c % 2 == 1) begin
        n_total++; if (grant_id !== 2'(((c - 1) / 2) % N)) $display("FAIL rr_gid c=%0d got=%0d exp=%0d", c, grant_id, ((c - 1) / 2) % N); else n_pass++;
        n_total++; if (data !== 8'(8'hC0 + ((c - 1) / 2) % N)) $display("FAIL rr_data c=%0d got=%h", c, data); else n_pass++;
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    fifo_full = 1'b1; req_valid = 4'b0010; req_addr[7 +: 7] = 7'h3C; req_data[8 +: 8] = 8'h5A;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++; if (req_ready !== 4'b0) $display("FAIL full_ready c=%0d got=%b exp=0", c, req_ready); else n_pass++;
      n_total++; if (fifo_wr_en !== 1'b0) $display("FAIL full_wr c=%0d got=%b exp=0", c, fifo_wr_en); else n_pass++;
    end
    @(posedge clk); #1 fifo_full = 1'b0;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0010) $display("FAIL full_release_ready got=%b exp=0010", req_ready); else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_total++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1 || addr !== 7'h3C)
      $display("FAIL full_release_wr got wr=%b gid=%0d addr=%h exp wr=1 gid=1 addr=3c", fifo_wr_en, grant_id, addr); else n_pass++;
  endtask

  task automatic test_dispatch();
    do_reset();
    fifo_empty = 1'b0; fsm_ready = 1'b1;
    @(negedge clk);
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL disp_idle_rd got=%b exp=0", fifo_rd_en); else n_pass++;
    @(posedge clk); #1 fsm_ready = 1'b0;
    @(negedge clk);
    n_total++; if (fifo_rd_en !== 1'b1) $display("FAIL disp_pop got=%b exp=1", fifo_rd_en); else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_total++; if (fifo_rd_en !== 1'b0 || tx_count !== 16'd0)
        $display("FAIL disp_busy c=%0d got rd=%b tx=%0d exp rd=0 tx=0", c, fifo_rd_en, tx_count); else n_pass++;
    end
    fsm_ready = 1'b1; fifo_empty = 1'b1;
    @(negedge clk);
    n_total++; if (tx_count !== 16'd1 || fifo_rd_en !== 1'b0)
      $display("FAIL disp_done got tx=%0d rd=%b exp tx=1 rd=0", tx_count, fifo_rd_en); else n_pass++;
    @(negedge clk);
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL disp_no_repop got=%b exp=0", fifo_rd_en); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    fifo_empty = 1'b0;
    @(posedge clk); #1 fifo_empty = 1'b1;
    @(negedge clk);
    n_total++; if (fifo_rd_en !== 1'b1) $display("FAIL to_pop got=%b exp=1", fifo_rd_en); else n_pass++;
    for (int n = 1; n <= BUSY_TO + 1; n++) begin
      @(negedge clk);
      n_total++; if (timeout_err !== 1'(n == BUSY_TO + 1))
        $display("FAIL to_flag n=%0d got=%b exp=%0d", n, timeout_err, n == BUSY_TO + 1); else n_pass++;
    end
    fifo_empty = 1'b0;
    @(negedge clk);
    n_total++; if (fifo_rd_en !== 1'b1 || timeout_err !== 1'b1)
      $display("FAIL to_back_idle got rd=%b to=%b exp rd=1 to=1", fifo_rd_en, timeout_err); else n_pass++;
    fifo_empty = 1'b1; arst = 1'b1;
    #1;
    n_total++; if (timeout_err !== 1'b0 || fifo_rd_en !== 1'b0 || tx_count !== 16'd0)
      $display("FAIL to_arst got to=%b rd=%b tx=%0d exp 0", timeout_err, fifo_rd_en, tx_count); else n_pass++;
    @(posedge clk); #1 arst = 1'b0;
  endtask

`ifdef I2C_CMD_SCHED_PRIO_EN
  task automatic test_prio();
    do_reset();
    req_valid = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_total++; if (req_ready !== ((c % 2 == 0) ? 4'b0001 : 4'b0000))
        $display("FAIL prio_ready c=%0d got=%b", c, req_ready); else n_pass++;
    end
    @(posedge clk); #1 req_valid = 4'b1000;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b1000) $display("FAIL prio_drop_ready got=%b exp=1000", req_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (grant_id !== 2'd3 || fifo_wr_en !== 1'b1)
      $display("FAIL prio_drop_gid got=%0d wr=%b exp gid=3 wr=1", grant_id, fifo_wr_en); else n_pass++;
  endtask
`endif

  localparam int PH_IDLE = 0, PH_POP = 1, PH_WAIT_BUSY = 2, PH_WAIT_DONE = 3;

  task automatic test_random();
    int         m_ptr, m_win, m_phase, n_phase, m_busy, m_tx, j;
    logic       m_wr, m_rd, m_to;
    logic [6:0] m_addr;
    logic [7:0] m_data;
    logic [1:0] m_gid;
    logic [3:0] exp_ready;
    int         errs;
    do_reset();
`ifdef I2C_CMD_SCHED_PRIO_EN
    m_ptr = 1;
`else
    m_ptr = 0;
`endif
    m_wr = 1'b0; m_rd = 1'b0; m_to = 1'b0; m_addr = '0; m_data = '0; m_gid = '0;
    m_phase = PH_IDLE; m_busy = 0; m_tx = 0; errs = 0;
    for (int c = 0; c < 3000; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      req_addr   = 28'($urandom);
      req_data   = $urandom;
      fifo_full  = ($urandom_range(0, 3) == 0);
      fifo_empty = 1'($urandom_range(0, 1));
      fsm_ready  = ((c / 150) % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      // Arbitration: winner is the first valid requester at or after the pointer.
      m_win = -1;
      if (!fifo_full && !m_wr) begin
`ifdef I2C_CMD_SCHED_PRIO_EN
        if (req_valid[0]) m_win = 0;
        for (int k = 0; k < N - 1; k++) begin
          j = 1 + ((m_ptr - 1 + k) % (N - 1));
          if (m_win < 0 && req_valid[j]) m_win = j;
        end
`else
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (m_win < 0 && req_valid[j]) m_win = j;
        end
`endif
      end
      exp_ready = (m_win >= 0) ? 4'(1 << m_win) : 4'b0;
      n_total++; if (req_ready !== exp_ready) begin errs++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end else n_pass++;
      n_total++; if (fifo_wr_en !== m_wr) begin errs++; $display("FAIL rnd_wr c=%0d got=%b exp=%b", c, fifo_wr_en, m_wr); end else n_pass++;
      n_total++; if (addr !== m_addr || data !== m_data) begin errs++; $display("FAIL rnd_cmd c=%0d got=%h/%h exp=%h/%h", c, addr, data, m_addr, m_data); end else n_pass++;
      n_total++; if (grant_id !== m_gid) begin errs++; $display("FAIL rnd_gid c=%0d got=%0d exp=%0d", c, grant_id, m_gid); end else n_pass++;
      n_total++; if (fifo_rd_en !== m_rd) begin errs++; $display("FAIL rnd_rd c=%0d got=%b exp=%b", c, fifo_rd_en, m_rd); end else n_pass++;
      n_total++; if (tx_count !== 16'(m_tx)) begin errs++; $display("FAIL rnd_tx c=%0d got=%0d exp=%0d", c, tx_count, m_tx); end else n_pass++;
      n_total++; if (timeout_err !== m_to) begin errs++; $display("FAIL rnd_to c=%0d got=%b exp=%b", c, timeout_err, m_to); end else n_pass++;
      if (errs > 20) begin
        $display("FAIL rnd_abort c=%0d too many mismatches", c);
        break;
      end
      m_wr = (m_win >= 0);
      if (m_win >= 0) begin
        m_addr = req_addr[m_win*7 +: 7];
        m_data = req_data[m_win*8 +: 8];
        m_gid  = 2'(m_win);
`ifdef I2C_CMD_SCHED_PRIO_EN
        if (m_win != 0) m_ptr = (m_win == N - 1) ? 1 : m_win + 1;
`else
        m_ptr = (m_win + 1) % N;
`endif
      end
      // Dispatch: one pop per completed transaction, with a bounded wait for the master to go busy.
      n_phase = m_phase;
      case (m_phase)
        PH_IDLE: if (fsm_ready && !fifo_empty) n_phase = PH_POP;
        PH_POP: begin n_phase = PH_WAIT_BUSY; m_busy = 0; end
        PH_WAIT_BUSY: begin
          if (!fsm_ready) n_phase = PH_WAIT_DONE;
          else begin
            m_busy++;
            if (m_busy == BUSY_TO) begin m_to = 1'b1; n_phase = PH_IDLE; end
          end
        end
        PH_WAIT_DONE: if (fsm_ready) begin m_tx = (m_tx + 1) % 65536; n_phase = PH_IDLE; end
        default: n_phase = PH_IDLE;
      endcase
      m_phase = n_phase;
      m_rd = (n_phase == PH_POP);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_single();
`ifdef I2C_CMD_SCHED_PRIO_EN
    test_prio();
`else
    test_round_robin();
`endif
    test_fifo_full();
    test_dispatch();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
